// File: rtl/mc_pkg.sv
// Shared constants for the memory-controller frame path (arbiter and FSM controller).
package mc_pkg;

    localparam int unsigned FRAME_WIDTH = 87;
    localparam int unsigned WR_BIT      = 84;

    // Frame direction as carried in bit WR_BIT.
    localparam logic DIR_RD = 1'b0;
    localparam logic DIR_WR = 1'b1;

endpackage

// File: rtl/mc_frame_arbiter_if.sv
// Requester-side and command-frame-side handshake bundle around the frame arbiter.
interface mc_frame_arbiter_if #(
    parameter int unsigned NUM_REQ     = 4,
    parameter int unsigned FRAME_WIDTH = mc_pkg::FRAME_WIDTH
);

    logic [NUM_REQ*FRAME_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]             req_valid;
    logic [NUM_REQ-1:0]             req_ready;
    logic [FRAME_WIDTH-1:0]         axi_frame_data;
    logic                           axi_frame_valid;
    logic                           axi_frame_ready;

    // Arbiter view.
    modport slave (
        input  req_data,
        input  req_valid,
        output req_ready,
        output axi_frame_data,
        output axi_frame_valid,
        input  axi_frame_ready
    );

    // Environment view: requesters plus the downstream consumer.
    modport master (
        output req_data,
        output req_valid,
        input  req_ready,
        input  axi_frame_data,
        input  axi_frame_valid,
        output axi_frame_ready
    );

endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set mask bit at or above i_ptr, wrapping.
module rr_pick #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_mask,
    input  logic [ID_W-1:0]    i_ptr,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [ID_W-1:0]    o_idx,
    output logic               o_any
);

    logic [2*NUM_REQ-1:0] w_dbl;
    logic                 w_found;

    // Lower copy drops requests below the pointer; upper copy supplies the wrap-around.
    always_comb begin
        w_dbl = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_dbl[i]           = i_mask[i] && (ID_W'(i) >= i_ptr);
            w_dbl[NUM_REQ + i] = i_mask[i];
        end
    end

    // Lowest set bit of the doubled vector wins; fold its position back into range.
    always_comb begin
        w_found = 1'b0;
        o_idx   = '0;
        o_grant = '0;
        for (int k = 0; k < 2 * NUM_REQ; k++) begin
            if (!w_found && w_dbl[k]) begin
                w_found = 1'b1;
                o_idx   = ID_W'(k % NUM_REQ);
            end
        end
        o_grant[o_idx] = w_found;
        o_any          = w_found;
    end

endmodule

// File: rtl/mc_frame_arbiter.sv
// Round-robin frame arbiter with read/write direction affinity feeding one registered slot.
module mc_frame_arbiter
    import mc_pkg::*;
#(
    parameter int unsigned NUM_REQ     = 4,
    parameter int unsigned FRAME_WIDTH = mc_pkg::FRAME_WIDTH,
    parameter int unsigned WR_BIT      = mc_pkg::WR_BIT,
    parameter int unsigned MAX_STREAK  = 4,
    parameter int unsigned ID_W        = $clog2(NUM_REQ)
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             mc_en,
    mc_frame_arbiter_if.slave                bus,
    output logic [ID_W-1:0]                  grant_id_o,
    output logic [$clog2(MAX_STREAK+1)-1:0]  streak_o
);

    localparam int unsigned ST_W = $clog2(MAX_STREAK + 1);

    logic [FRAME_WIDTH-1:0] r_data;
    logic                   r_valid;
    logic [ID_W-1:0]        r_grant_id;
    logic [ID_W-1:0]        r_rr_ptr;
    logic [ST_W-1:0]        r_streak;
    logic                   r_last_dir;

    logic [NUM_REQ-1:0]     w_dir;
    logic [NUM_REQ-1:0]     w_match;
    logic [NUM_REQ-1:0]     w_cand;
    logic [NUM_REQ-1:0]     w_grant;
    logic [ID_W-1:0]        w_sel;
    logic                   w_any;
    logic                   w_affinity;
    logic                   w_slot_free;
    logic                   w_load;
    logic                   w_sel_dir;
    logic [FRAME_WIDTH-1:0] w_sel_data;
    logic [ID_W-1:0]        w_ptr_next;
    logic [ST_W-1:0]        w_streak_next;

    // Extract each requester's direction bit.
    always_comb begin
        w_dir = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_dir[i] = bus.req_data[i * FRAME_WIDTH + WR_BIT];
        end
    end

    // Affinity narrows candidates to the current direction until the streak saturates.
    always_comb begin
        w_match    = bus.req_valid & ~(w_dir ^ {NUM_REQ{r_last_dir}});
        w_affinity = (r_streak < ST_W'(MAX_STREAK)) && (|w_match);
        w_cand     = w_affinity ? w_match : bus.req_valid;
    end

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr_pick (
        .i_mask  (w_cand),
        .i_ptr   (r_rr_ptr),
        .o_grant (w_grant),
        .o_idx   (w_sel),
        .o_any   (w_any)
    );

    // Load decision and the selected frame's next-state values.
    always_comb begin
        w_slot_free   = !r_valid || bus.axi_frame_ready;
        w_load        = !rst && mc_en && w_slot_free && w_any;
        w_sel_data    = bus.req_data[int'(w_sel) * FRAME_WIDTH +: FRAME_WIDTH];
        w_sel_dir     = w_dir[w_sel];
        w_ptr_next    = (w_sel == ID_W'(NUM_REQ - 1)) ? '0 : w_sel + 1'b1;
        if (w_sel_dir != r_last_dir) begin
            w_streak_next = ST_W'(1);
        end else if (r_streak == ST_W'(MAX_STREAK)) begin
            w_streak_next = r_streak;
        end else begin
            w_streak_next = r_streak + 1'b1;
        end
    end

    // Ready goes only to the port being loaded this cycle.
    always_comb begin
        bus.req_ready = w_load ? w_grant : '0;
    end

    // Slot register and arbitration state; reset drops any held frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_data     <= '0;
            r_valid    <= 1'b0;
            r_grant_id <= '0;
            r_rr_ptr   <= '0;
            r_streak   <= '0;
            r_last_dir <= DIR_RD;
        end else if (w_load) begin
            r_data     <= w_sel_data;
            r_valid    <= 1'b1;
            r_grant_id <= w_sel;
            r_rr_ptr   <= w_ptr_next;
            r_streak   <= w_streak_next;
            r_last_dir <= w_sel_dir;
        end else if (bus.axi_frame_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign bus.axi_frame_data  = r_data;
    assign bus.axi_frame_valid = r_valid;
    assign grant_id_o          = r_grant_id;
    assign streak_o            = r_streak;

endmodule

// File: tb/tb_mc_frame_arbiter.sv
// Directed plus randomized bench for mc_frame_arbiter against a cycle-level reference model.
module tb_mc_frame_arbiter;
    import mc_pkg::*;

    localparam int N    = 4;
    localparam int FW   = FRAME_WIDTH;
    localparam int WRB  = WR_BIT;
    localparam int MAXS = 4;
    localparam int IDW  = 2;
    localparam int STW  = 3;

    logic           clk = 1'b0;
    logic           rst;
    logic           mc_en;
    logic [IDW-1:0] grant_id;
    logic [STW-1:0] streak;

    mc_frame_arbiter_if #(.NUM_REQ(N), .FRAME_WIDTH(FW)) bus ();

    mc_frame_arbiter #(
        .NUM_REQ     (N),
        .FRAME_WIDTH (FW),
        .WR_BIT      (WRB),
        .MAX_STREAK  (MAXS),
        .ID_W        (IDW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .mc_en       (mc_en),
        .bus         (bus),
        .grant_id_o  (grant_id),
        .streak_o    (streak)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state, expressed directly in terms of the arbitration rules.
    logic          m_valid  = 1'b0;
    logic [FW-1:0] m_data   = '0;
    int            m_gid    = 0;
    int            m_ptr    = 0;
    int            m_streak = 0;
    logic          m_last   = DIR_RD;
    int            last_sel = -1;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [FW-1:0] mk_frame(input logic dir);
        logic [95:0]   r;
        logic [FW-1:0] f;
        r      = {$urandom(), $urandom(), $urandom()};
        f      = r[FW-1:0];
        f[WRB] = dir;
        return f;
    endfunction

    task automatic set_port(input int p, input logic v, input logic dir);
        bus.req_data[p*FW +: FW] = mk_frame(dir);
        bus.req_valid[p]         = v;
    endtask

    function automatic logic port_dir(input int p);
        return bus.req_data[p*FW + WRB];
    endfunction

    // Walk ports from the pointer; prefer the current direction while the streak allows it.
    function automatic int model_sel();
        bit aff = 1'b0;
        for (int p = 0; p < N; p++) begin
            if (bus.req_valid[p] && port_dir(p) == m_last) aff = 1'b1;
        end
        aff = aff && (m_streak < MAXS);
        for (int k = 0; k < N; k++) begin
            int p;
            p = (m_ptr + k) % N;
            if (bus.req_valid[p] && (!aff || port_dir(p) == m_last)) return p;
        end
        return -1;
    endfunction

    // One clock: check DUT against the model mid-cycle, then advance the model.
    task automatic step(input string tag);
        int           sel;
        logic         load;
        logic [N-1:0] exp_ready;
        @(negedge clk);
        sel       = model_sel();
        load      = !rst && mc_en && (!m_valid || bus.axi_frame_ready) && (bus.req_valid != 0);
        exp_ready = load ? (N'(1) << sel) : '0;
        chk($sformatf("%s ready", tag), 128'(bus.req_ready), 128'(exp_ready));
        chk($sformatf("%s valid", tag), 128'(bus.axi_frame_valid), 128'(m_valid));
        chk($sformatf("%s data", tag), 128'(bus.axi_frame_data), 128'(m_data));
        chk($sformatf("%s gid", tag), 128'(grant_id), 128'(m_gid));
        chk($sformatf("%s streak", tag), 128'(streak), 128'(m_streak));
        last_sel = load ? sel : -1;
        if (rst) begin
            m_valid = 1'b0; m_data = '0; m_gid = 0; m_ptr = 0; m_streak = 0; m_last = DIR_RD;
        end else if (load) begin
            if (port_dir(sel) == m_last) begin
                m_streak = (m_streak + 1 > MAXS) ? MAXS : m_streak + 1;
            end else begin
                m_streak = 1;
                m_last   = port_dir(sel);
            end
            m_ptr   = (sel + 1) % N;
            m_valid = 1'b1;
            m_data  = bus.req_data[sel*FW +: FW];
            m_gid   = sel;
        end else if (bus.axi_frame_ready) begin
            m_valid = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst                 = 1'b1;
        mc_en               = 1'b1;
        bus.req_valid       = '1;
        bus.req_data        = '0;
        bus.axi_frame_ready = 1'b1;
        @(posedge clk);
        #1;
        // Reset holds even with every port requesting.
        step("rst");

        // Idle, then a single read request.
        rst           = 1'b0;
        bus.req_valid = '0;
        step("idle");
        set_port(0, 1'b1, DIR_RD);
        step("t1 load");
        chk("t1 valid", 128'(bus.axi_frame_valid), 128'(1));
        chk("t1 gid", 128'(grant_id), 128'(0));
        chk("t1 streak", 128'(streak), 128'(1));

        // Fairness: all ports reading continuously.
        for (int p = 0; p < N; p++) set_port(p, 1'b1, DIR_RD);
        for (int c = 0; c < 10; c++) step("fair");
        chk("fair streak sat", 128'(streak), 128'(MAXS));

        // Affinity: a write flips direction, then writes win over an earlier read.
        bus.req_valid = '0;
        set_port(0, 1'b1, DIR_WR);
        step("aff w0");
        chk("aff gid0", 128'(grant_id), 128'(0));
        set_port(0, 1'b0, DIR_WR);
        set_port(1, 1'b1, DIR_RD);
        set_port(2, 1'b1, DIR_WR);
        set_port(3, 1'b1, DIR_WR);
        step("aff a");
        chk("aff gid2", 128'(grant_id), 128'(2));
        bus.req_valid[2] = 1'b0;
        step("aff b");
        chk("aff gid3", 128'(grant_id), 128'(3));
        bus.req_valid[3] = 1'b0;
        step("aff c");
        chk("aff gid1", 128'(grant_id), 128'(1));
        chk("aff streak1", 128'(streak), 128'(1));

        // Streak cap: writers on 0 and 2, a reader on 1.
        bus.req_valid = '0;
        set_port(0, 1'b1, DIR_WR);
        set_port(1, 1'b1, DIR_RD);
        set_port(2, 1'b1, DIR_WR);
        for (int c = 0; c < 14; c++) step("cap");

        // Backpressure with everyone requesting, then release.
        for (int p = 0; p < N; p++) set_port(p, 1'b1, p[0]);
        step("bp fill");
        bus.axi_frame_ready = 1'b0;
        for (int c = 0; c < 3; c++) step("bp hold");
        bus.axi_frame_ready = 1'b1;
        step("bp release");

        // Enable drop with a held frame, drain while disabled, then resume.
        bus.axi_frame_ready = 1'b0;
        step("en fill");
        mc_en = 1'b0;
        step("en hold");
        bus.axi_frame_ready = 1'b1;
        for (int c = 0; c < 3; c++) step("en off");
        mc_en = 1'b1;
        for (int c = 0; c < 4; c++) step("en on");

        // Reset mid-stream.
        rst = 1'b1;
        step("mid rst");
        rst = 1'b0;
        for (int c = 0; c < 3; c++) step("post rst");

        // Randomized traffic; requesters hold frames until granted.
        for (int c = 0; c < 400; c++) begin
            rst                 = ($urandom_range(99) == 0);
            mc_en               = ($urandom_range(7) != 0);
            bus.axi_frame_ready = ($urandom_range(3) != 0);
            step("rand");
            for (int p = 0; p < N; p++) begin
                if (!bus.req_valid[p] || p == last_sel) begin
                    set_port(p, 1'($urandom_range(1)), 1'($urandom_range(1)));
                end
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mc_frame_arbiter.md
Name: mc_frame_arbiter

Overview:
Shares the single memory-controller command-frame port (axi_frame_data/valid/ready into the MC FSM controller) between NUM_REQ upstream requesters.
Selection is round-robin with a direction-affinity policy: consecutive frames of the same direction (write/read, frame bit WR_BIT) are preferred up to MAX_STREAK grants, which reduces read/write turnarounds.
The output is one registered frame slot, giving 1-cycle latency and full 1-frame/cycle throughput.
The block sits between the AXI frame packers and the MC FSM controller.

Parameters:
NUM_REQ, 4, number of requester ports (2..8)
FRAME_WIDTH, 87, frame width in bits
WR_BIT, 84, frame bit index: 1 = write, 0 = read
MAX_STREAK, 4, max consecutive same-direction grants while affinity is active (>=1)
ID_W, 2, grant id width, = clog2(NUM_REQ)

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
mc_en  in  1  enable; low blocks new grants
req_data  in  NUM_REQ*FRAME_WIDTH  requester frames, port i at [i*FRAME_WIDTH +: FRAME_WIDTH]
req_valid  in  NUM_REQ  requester valid
req_ready  out  NUM_REQ  requester ready, one-hot or zero
axi_frame_data  out  FRAME_WIDTH  registered granted frame
axi_frame_valid  out  1  registered valid
axi_frame_ready  in  1  downstream ready
grant_id_o  out  ID_W  source port of the held frame
streak_o  out  clog2(MAX_STREAK+1)  current same-direction streak count

Behaviour:
- Clock and reset: single clock clk. Reset rst is synchronous and active-high.
- Reset values: axi_frame_valid=0, axi_frame_data=0, grant_id_o=0, streak_o=0, rr_ptr=0, last_dir=0 (read).
- req_ready is combinational.
- slot_free = !axi_frame_valid || axi_frame_ready.
- load = mc_en && slot_free && |req_valid.
- req_ready[sel] = load; all other ready bits are 0.
- Port i transfers when req_valid[i] && req_ready[i].
- Selection, when req_valid != 0:
  - dir_i = req_data[i][WR_BIT].
  - match = req_valid & (dir_i == last_dir).
  - If streak < MAX_STREAK and match != 0, the candidate set is match. Otherwise it is req_valid.
  - sel = the first candidate found scanning upward from rr_ptr, modulo NUM_REQ.
- On load:
  - axi_frame_data <= req_data[sel], axi_frame_valid <= 1, grant_id_o <= sel.
  - rr_ptr <= (sel+1) mod NUM_REQ.
  - If dir_sel == last_dir, streak <= min(streak+1, MAX_STREAK). Otherwise streak <= 1 and last_dir <= dir_sel.
- Slot drains with no new load (axi_frame_ready=1, load=0): axi_frame_valid <= 0. Data and grant_id hold their values.
- Slot held (axi_frame_valid=1, axi_frame_ready=0): data, valid and grant_id are stable. All req_ready are 0.
- Once streak == MAX_STREAK, selection is plain round-robin until a direction change resets streak to 1.
- mc_en=0: no loads. A frame already held stays valid until accepted. rr_ptr, streak and last_dir are retained.
- Single requester: sel = that port, regardless of rr_ptr or affinity.
- Latency: request accepted in cycle N appears on axi_frame_valid in cycle N+1. Back-to-back transfers occur with axi_frame_ready held at 1.
- Requester rules: requesters must hold req_valid/req_data until ready. The arbiter does not check this.
- Reset mid-operation: a held frame is dropped. No req_ready is asserted in the cycle rst=1.

Decomposition:
- Package mc_pkg: FRAME_WIDTH, WR_BIT and the direction constants DIR_RD=0 and DIR_WR=1. The MC FSM controller also uses this package.
- Sub-module rr_pick:
  - Parameter NUM_REQ.
  - Inputs: candidate mask, start pointer.
  - Outputs: one-hot grant, encoded index, any.
  - Purely combinational: double-width mask-and-priority.
- The top holds the slot register, rr_ptr, streak and last_dir.

Test Plan:
1. Reset then idle. Expect axi_frame_valid=0, req_ready=0000, streak_o=0. Assert req_valid=0001 with a read frame -> req_ready=0001 in the same cycle; next cycle axi_frame_valid=1, grant_id_o=0, streak_o=1.
2. Fairness, all ports requesting reads continuously, axi_frame_ready=1, MAX_STREAK=4 -> grant order 0,1,2,3,0,1… with one frame per cycle. streak_o saturates at 4.
3. Affinity after a write from port 0 (last_dir=WR): port1=read, port2=write, port3=write, rr_ptr=1 -> grants 2,3 (writes) before 1 while streak<4.
4. Streak cap: 5 write ports... use NUM_REQ=4 with ports 0,2 always writing and port 1 reading -> after 4 consecutive writes, port 1 is granted next. streak_o resets to 1 and last_dir flips to read.
5. Backpressure: axi_frame_ready=0 for 3 cycles with a frame held -> axi_frame_data/grant_id_o stable and req_ready=0000. Release -> held frame accepted and a new load in that same cycle.
6. mc_en drop with a frame held -> the frame stays valid and is accepted when ready. No new grants while mc_en=0. After re-enable, round-robin resumes from the retained rr_ptr. Reset asserted mid-stream -> valid=0 on the next cycle.
